alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one external combinational ALU.
// One operation is in flight at a time: IDLE grants, EXEC waits ALU_LAT cycles, RESP holds the result.
module alu_arbiter #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_req0_valid,
    input  logic [NB_DATA-1:0] i_req0_a,
    input  logic [NB_DATA-1:0] i_req0_b,
    input  logic [NB_OP-1:0]   i_req0_op,
    output logic               o_req0_ready,
    input  logic               i_req1_valid,
    input  logic [NB_DATA-1:0] i_req1_a,
    input  logic [NB_DATA-1:0] i_req1_b,
    input  logic [NB_OP-1:0]   i_req1_op,
    output logic               o_req1_ready,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_rsp_valid,
    output logic               o_rsp_id,
    output logic [NB_DATA-1:0] o_rsp_data,
    output logic               o_rsp_err,
    input  logic               i_rsp_ready,
    output logic               o_busy
);

    localparam int NB_CNT = 4;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic [NB_CNT-1:0]   r_cnt;
    logic                w_gnt;
    logic                w_accept;
    logic                w_supp;
    logic                w_exec_done;
    logic [NB_DATA-1:0]  w_a;
    logic [NB_DATA-1:0]  w_b;
    logic [NB_OP-1:0]    w_op;
    logic [NB_DATA-1:0]  r_alu_a;
    logic [NB_DATA-1:0]  r_alu_b;
    logic [NB_OP-1:0]    r_alu_op;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [NB_DATA-1:0]  r_rsp_data;
    logic                r_rsp_err;
    logic                r_busy;

    function automatic logic op_supported(input logic [NB_OP-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_supported = 1'b1;
            default:                        op_supported = 1'b0;
        endcase
    endfunction

    // Grant selection: a lone requester wins, contention goes to the one not granted last.
    always_comb begin
        w_gnt = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            w_gnt = ~r_last;
        end else if (i_req1_valid) begin
            w_gnt = 1'b1;
        end else begin
            w_gnt = 1'b0;
        end
    end

    // Operand/opcode mux of the granted requester.
    always_comb begin
        w_a  = i_req0_a;
        w_b  = i_req0_b;
        w_op = i_req0_op;
        if (w_gnt) begin
            w_a  = i_req1_a;
            w_b  = i_req1_b;
            w_op = i_req1_op;
        end else begin
            w_a  = i_req0_a;
            w_b  = i_req0_b;
            w_op = i_req0_op;
        end
    end

    // Reset gates acceptance so it wins over a simultaneous request.
    assign w_accept     = (r_state == ST_IDLE) && !i_rst && (i_req0_valid || i_req1_valid);
    assign w_supp       = op_supported(w_op);
    assign w_exec_done  = (r_cnt == NB_CNT'(ALU_LAT - 1));
    assign o_req0_ready = w_accept && !w_gnt;
    assign o_req1_ready = w_accept && w_gnt;

    // State register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_supp ? ST_EXEC : ST_RESP;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (w_exec_done) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture on accept, count EXEC cycles, latch the ALU result on the last one.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last   <= w_gnt;
                        r_rsp_id <= w_gnt;
                        r_cnt    <= '0;
                        if (w_supp) begin
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                            r_alu_op <= w_op;
                        end else begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + NB_CNT'(1);
                    if (w_exec_done) begin
                        r_rsp_data <= i_alu_result;
                        r_rsp_err  <= 1'b0;
                    end
                end
                ST_RESP: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Status flags registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= (w_next == ST_RESP);
            r_busy      <= (w_next != ST_IDLE);
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = r_busy;

endmodule
